// File: rtl/calc_seq_if.sv
// rtl/calc_seq_if.sv - Bundle of the job, term-stream, calc and result signals for calc_seq
//
// Signals:
//   start, len                         job request and term count
//   bit_valid, bit_data, bit_ready     upstream term stream handshake
//   calc_rst, calc_1, calc_in          controls toward the calc unit
//   agg_out2alu, agg_out_acted         aggregate and activation back from calc
//   res_valid, res_data, res_acted,
//   res_ready                          held result handshake
//   busy                               sequencer not idle
// Modports: slave is the sequencer side, master is the surrounding system.

interface calc_seq_if #(
    parameter int alu_width = 12,
    parameter int cnt_width = 8
);
    logic                 start;
    logic [cnt_width-1:0] len;
    logic                 bit_valid;
    logic                 bit_data;
    logic                 bit_ready;
    logic                 calc_rst;
    logic                 calc_1;
    logic                 calc_in;
    logic [alu_width-1:0] agg_out2alu;
    logic                 agg_out_acted;
    logic                 res_valid;
    logic [alu_width-1:0] res_data;
    logic                 res_acted;
    logic                 res_ready;
    logic                 busy;

    modport slave (
        input  start, len, bit_valid, bit_data, agg_out2alu, agg_out_acted, res_ready,
        output bit_ready, calc_rst, calc_1, calc_in, res_valid, res_data, res_acted, busy
    );

    modport master (
        output start, len, bit_valid, bit_data, agg_out2alu, agg_out_acted, res_ready,
        input  bit_ready, calc_rst, calc_1, calc_in, res_valid, res_data, res_acted, busy
    );
endinterface

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - Job sequencer feeding bit-serial terms into one calc unit
//
// Ports:
//   clk   rising-edge system clock
//   rst   synchronous active-high reset (also clears calc through calc_rst)
//   bus   calc_seq_if.slave: job request, term stream in, calc controls,
//         calc aggregate in, held result out, busy
//
// Flow: IDLE -> CLR (one cycle of calc_rst) -> FEED (len accepted terms)
//       -> DRAIN (drain_lat cycles) -> RESULT (held until res_ready) -> IDLE.
//       A zero-length job skips FEED.

module calc_seq #(
    parameter int alu_width = 12,
    parameter int cnt_width = 8,
    parameter int drain_lat = 1
) (
    input  logic      clk,
    input  logic      rst,
    calc_seq_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam int                   drain_w    = (drain_lat > 1) ? $clog2(drain_lat) : 1;
    localparam logic [drain_w-1:0]   drain_last = drain_w'(drain_lat - 1);
    localparam logic [drain_w-1:0]   drain_one  = drain_w'(1);
    localparam logic [cnt_width-1:0] cnt_one    = cnt_width'(1);

    logic [2:0]           state;
    logic [cnt_width-1:0] len_q;
    logic [cnt_width-1:0] cnt;
    logic [drain_w-1:0]   drain_cnt;
    logic                 res_valid_q;
    logic [alu_width-1:0] res_data_q;
    logic                 res_acted_q;

    logic in_feed;
    logic accept;
    logic last_term;

    assign in_feed = (state == S_FEED);
    assign accept  = in_feed && bus.bit_valid;
    // Full-width compare against len-1 so len = 2^cnt_width-1 ends before cnt could wrap.
    assign last_term = (cnt == (len_q - cnt_one));

    // Term path is combinational so each accepted term reaches calc in its own cycle.
    assign bus.bit_ready = in_feed;
    assign bus.calc_1    = accept;
    assign bus.calc_in   = accept && bus.bit_data;
    assign bus.calc_rst  = rst || (state == S_CLR);
    assign bus.busy      = (state != S_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_acted = res_acted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            len_q       <= '0;
            cnt         <= '0;
            drain_cnt   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_acted_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q <= bus.len;
                        cnt   <= '0;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    drain_cnt <= '0;
                    state     <= (len_q != '0) ? S_FEED : S_DRAIN;
                end
                S_FEED: begin
                    if (accept) begin
                        cnt <= cnt + cnt_one;
                        if (last_term) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == drain_last) begin
                        res_data_q  <= bus.agg_out2alu;
                        res_acted_q <= bus.agg_out_acted;
                        res_valid_q <= 1'b1;
                        state       <= S_RESULT;
                    end else begin
                        drain_cnt <= drain_cnt + drain_one;
                    end
                end
                S_RESULT: begin
                    // start is ignored here, even alongside the handshake.
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - Self-checking bench for calc_seq with a behavioural calc model

module tb_calc_seq;

    localparam int alu_width = 12;
    localparam int cnt_width = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    calc_seq_if #(.alu_width(alu_width), .cnt_width(cnt_width)) bus ();

    calc_seq #(
        .alu_width(alu_width),
        .cnt_width(cnt_width),
        .drain_lat(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // calc model: accumulator visible combinationally, activation when sum >= 2.
    logic [alu_width-1:0] acc = '0;
    always @(posedge clk) begin
        if (bus.calc_rst)
            acc <= '0;
        else if (bus.calc_1)
            acc <= acc + {{(alu_width-1){1'b0}}, bus.calc_in};
    end
    assign bus.agg_out2alu   = acc;
    assign bus.agg_out_acted = (acc >= 12'd2);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  len;
        logic [15:0] data;
        int          b_at;
        int          b_n;
        int          exp_data;
        int          exp_acted;
        int          exp_lat;
        int          exp_strobes;
    } vec_t;

    vec_t vecs[6];

    // Launch a job and feed terms until res_valid; returns at a negedge with res_valid seen.
    task automatic run_job(input logic [3:0] l, input logic [15:0] d, input int b_at, input int b_n,
                           output int lat, output int strobes, output int readies,
                           output int rpulses, output int bub_err, output bit timeout);
        int term;
        int bub_left;
        lat = 0; strobes = 0; readies = 0; rpulses = 0; bub_err = 0; timeout = 1'b0;
        term = 0;
        bub_left = b_n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.res_valid && !timeout) begin
            if (bus.calc_rst) rpulses++;
            if (bus.bit_ready) begin
                readies++;
                if (term == b_at && bub_left > 0) begin
                    bus.bit_valid = 1'b0;
                    bus.bit_data  = 1'b1;
                    bub_left--;
                    #1;
                    if (bus.calc_1 || bus.calc_in) bub_err++;
                end else begin
                    bus.bit_valid = 1'b1;
                    bus.bit_data  = (term < 16) ? d[term] : 1'b0;
                    term++;
                    #1;
                    if (bus.calc_1) strobes++;
                end
            end else begin
                bus.bit_valid = 1'b0;
                bus.bit_data  = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat > 100) timeout = 1'b1;
        end
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b0;
    endtask

    int  lat, strobes, readies, rpulses, bub_err;
    bit  timeout;

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b0;
        bus.res_ready = 1'b0;

        //          len    data      b_at b_n data acted lat strobes
        vecs[0] = '{4'd4,  16'h000D, 99,  0,  3,   1,    6,  4};
        vecs[1] = '{4'd4,  16'h000D, 2,   2,  3,   1,    8,  4};
        vecs[2] = '{4'd0,  16'h0000, 99,  0,  0,   0,    2,  0};
        vecs[3] = '{4'd15, 16'h7FFF, 99,  0,  15,  1,    17, 15};
        vecs[4] = '{4'd1,  16'h0000, 99,  0,  0,   0,    3,  1};
        vecs[5] = '{4'd2,  16'h0003, 99,  0,  2,   1,    4,  2};

        // Reset state, with a stray term offered while not in FEED.
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.bit_valid = 1'b1;
        bus.bit_data  = 1'b1;
        #1;
        chk("rst_calc_rst", int'(bus.calc_rst), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_data", int'(bus.res_data), 0);
        chk("rst_res_acted", int'(bus.res_acted), 0);
        chk("rst_bit_ready", int'(bus.bit_ready), 0);
        chk("rst_calc_1", int'(bus.calc_1), 0);
        chk("rst_calc_in", int'(bus.calc_in), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_calc_rst", int'(bus.calc_rst), 0);
        chk("idle_bit_ready", int'(bus.bit_ready), 0);
        chk("idle_calc_1", int'(bus.calc_1), 0);
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].len, vecs[i].data, vecs[i].b_at, vecs[i].b_n,
                    lat, strobes, readies, rpulses, bub_err, timeout);
            chk($sformatf("v%0d_timeout", i), int'(timeout), 0);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_res_data", i), int'(bus.res_data), vecs[i].exp_data);
            chk($sformatf("v%0d_res_acted", i), int'(bus.res_acted), vecs[i].exp_acted);
            chk($sformatf("v%0d_strobes", i), strobes, vecs[i].exp_strobes);
            chk($sformatf("v%0d_ready_cycles", i), readies, int'(vecs[i].len) + vecs[i].b_n);
            chk($sformatf("v%0d_calc_rst_pulses", i), rpulses, 1);
            chk($sformatf("v%0d_bubble_leak", i), bub_err, 0);
            bus.res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.res_ready = 1'b0;
            chk($sformatf("v%0d_idle_after", i), int'(bus.busy), 0);
            chk($sformatf("v%0d_valid_dropped", i), int'(bus.res_valid), 0);
            chk($sformatf("v%0d_data_kept", i), int'(bus.res_data), vecs[i].exp_data);
        end

        // Backpressure with a start pulse while busy, then start coincident with handshake.
        run_job(4'd2, 16'h0003, 99, 0, lat, strobes, readies, rpulses, bub_err, timeout);
        chk("bp_timeout", int'(timeout), 0);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            bus.len   = 4'd5;
            #1;
            chk($sformatf("bp%0d_valid", i), int'(bus.res_valid), 1);
            chk($sformatf("bp%0d_data", i), int'(bus.res_data), 2);
            chk($sformatf("bp%0d_busy", i), int'(bus.busy), 1);
            @(posedge clk);
            @(negedge clk);
        end
        bus.start     = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        chk("hs_start_busy", int'(bus.busy), 0);
        chk("hs_start_calc_rst", int'(bus.calc_rst), 0);
        chk("hs_valid", int'(bus.res_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk("hs_start_not_queued", int'(bus.busy), 0);

        // Reset in the middle of FEED after two of four terms.
        bus.start = 1'b1;
        bus.len   = 4'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_feed_ready", int'(bus.bit_ready), 1);
        bus.bit_valid = 1'b1;
        bus.bit_data  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_acc_partial", int'(acc), 2);
        chk("mid_calc_rst_during_rst", int'(bus.calc_rst), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_busy", int'(bus.busy), 0);
        chk("mid_bit_ready", int'(bus.bit_ready), 0);
        chk("mid_calc_1", int'(bus.calc_1), 0);
        chk("mid_res_valid", int'(bus.res_valid), 0);
        chk("mid_res_data", int'(bus.res_data), 0);
        chk("mid_calc_rst_after", int'(bus.calc_rst), 0);
        chk("mid_acc_cleared", int'(acc), 0);
        run_job(4'd2, 16'h0003, 99, 0, lat, strobes, readies, rpulses, bub_err, timeout);
        chk("post_rst_timeout", int'(timeout), 0);
        chk("post_rst_data", int'(bus.res_data), 2);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_strobes", strobes, 2);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("post_rst_idle", int'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
